// File: rtl/lcd_pkg.sv
// Shared definitions for the ST7735 PMOD LCD path: transmitter state encoding,
// controller opcodes, panel geometry and D/C pin levels.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_END   = 3'd4,
        ST_GAP   = 3'd5
    } tx_state_t;

    localparam logic [7:0] OP_SLPOUT = 8'h11;
    localparam logic [7:0] OP_CASET  = 8'h2A;
    localparam logic [7:0] OP_RASET  = 8'h2B;
    localparam logic [7:0] OP_RAMWR  = 8'h2C;
    localparam logic [7:0] OP_COLMOD = 8'h3A;
    localparam logic [7:0] OP_MADCTL = 8'h36;
    localparam logic [7:0] OP_DISPON = 8'h29;

    localparam int LCD_W = 80;
    localparam int LCD_H = 160;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

endpackage

// File: rtl/lcd_spi_byte_tx_if.sv
// Byte handshake between the command/pixel sequencer (master) and the SPI
// byte transmitter (slave).
interface lcd_spi_byte_tx_if;

    logic       TX_VALID;
    logic [7:0] TX_DATA;
    logic       TX_DC;
    logic       TX_LAST;
    logic       TX_READY;
    logic       BUSY;

    modport master (
        output TX_VALID, TX_DATA, TX_DC, TX_LAST,
        input  TX_READY, BUSY
    );

    modport slave (
        input  TX_VALID, TX_DATA, TX_DC, TX_LAST,
        output TX_READY, BUSY
    );

endinterface

// File: rtl/lcd_spi_byte_tx.sv
// Serialises one byte per handshake MSB-first onto the ST7735 SPI pins (mode 3),
// holding CS low across bytes until a byte flagged as last has gone out.
module lcd_spi_byte_tx
    import lcd_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    lcd_spi_byte_tx_if.slave  tx,
    output logic              SCL,
    output logic              MOSI,
    output logic              DC,
    output logic              CS
);

    localparam int              CW       = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLK_DIV - 1);

    tx_state_t     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    data_reg, data_next;
    logic          last_reg, last_next;
    logic          gap_half_reg, gap_half_next;
    logic          scl_reg, scl_next;
    logic          mosi_reg, mosi_next;
    logic          dc_reg, dc_next;
    logic          cs_reg, cs_next;

    logic          tx_ready;
    logic          accept;
    logic          phase_end;

    assign tx_ready  = (state_reg == ST_IDLE) & ~RESET;
    assign accept    = tx.TX_VALID & tx_ready;
    assign phase_end = (cnt_reg == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            bit_reg      <= 3'd7;
            data_reg     <= 8'h00;
            last_reg     <= 1'b0;
            gap_half_reg <= 1'b0;
            scl_reg      <= 1'b1;
            mosi_reg     <= 1'b1;
            dc_reg       <= 1'b1;
            cs_reg       <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_reg      <= bit_next;
            data_reg     <= data_next;
            last_reg     <= last_next;
            gap_half_reg <= gap_half_next;
            scl_reg      <= scl_next;
            mosi_reg     <= mosi_next;
            dc_reg       <= dc_next;
            cs_reg       <= cs_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_next      = bit_reg;
        data_next     = data_reg;
        last_next     = last_reg;
        gap_half_next = gap_half_reg;
        scl_next      = scl_reg;
        mosi_next     = mosi_reg;
        dc_next       = dc_reg;
        cs_next       = cs_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    data_next  = tx.TX_DATA;
                    last_next  = tx.TX_LAST;
                    dc_next    = tx.TX_DC;
                    cs_next    = 1'b0;
                    mosi_next  = tx.TX_DATA[7];
                    bit_next   = 3'd7;
                    cnt_next   = '0;
                    state_next = ST_SETUP;
                end
            end

            // SCL stays high here so CS/DC/MOSI settle before the first falling edge.
            ST_SETUP: begin
                if (phase_end) begin
                    cnt_next   = '0;
                    scl_next   = 1'b0;
                    state_next = ST_LOW;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_LOW: begin
                if (phase_end) begin
                    cnt_next   = '0;
                    scl_next   = 1'b1;
                    state_next = ST_HIGH;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_HIGH: begin
                if (phase_end) begin
                    cnt_next = '0;
                    if (bit_reg == 3'd0) begin
                        state_next = ST_END;
                    end else begin
                        bit_next   = bit_reg - 3'd1;
                        mosi_next  = data_reg[bit_reg - 3'd1];
                        scl_next   = 1'b0;
                        state_next = ST_LOW;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_END: begin
                if (last_reg) begin
                    cs_next       = 1'b1;
                    gap_half_next = 1'b0;
                    state_next    = ST_GAP;
                end else begin
                    state_next = ST_IDLE;
                end
            end

            // Two D-cycle halves keep the counter at its narrow width.
            ST_GAP: begin
                if (phase_end) begin
                    cnt_next = '0;
                    if (gap_half_reg) begin
                        gap_half_next = 1'b0;
                        state_next    = ST_IDLE;
                    end else begin
                        gap_half_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign tx.TX_READY = tx_ready;
    assign tx.BUSY     = (state_reg != ST_IDLE);
    assign SCL         = scl_reg;
    assign MOSI        = mosi_reg;
    assign DC          = dc_reg;
    assign CS          = cs_reg;

endmodule

// File: tb/tb_lcd_spi_byte_tx.sv
// Directed bench for lcd_spi_byte_tx: a D=1 instance with a bus-level receiver model
// and a D=4 instance measured cycle by cycle.
module tb_lcd_spi_byte_tx;
    import lcd_pkg::*;

    localparam int BURST_N = 2000;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    lcd_spi_byte_tx_if bus1();
    lcd_spi_byte_tx_if bus4();

    logic scl1, mosi1, dc1, cs1;
    logic scl4, mosi4, dc4, cs4;

    lcd_spi_byte_tx #(.CLK_DIV(1)) dut1 (
        .CLK   (CLK),
        .RESET (RESET),
        .tx    (bus1),
        .SCL   (scl1),
        .MOSI  (mosi1),
        .DC    (dc1),
        .CS    (cs1)
    );

    lcd_spi_byte_tx #(.CLK_DIV(4)) dut4 (
        .CLK   (CLK),
        .RESET (RESET),
        .tx    (bus4),
        .SCL   (scl4),
        .MOSI  (mosi4),
        .DC    (dc4),
        .CS    (cs4)
    );

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;
    int cyc           = 0;
    int last_accept   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Receiver model for the D=1 instance: samples MOSI on SCL rising while CS is low.
    logic       scl1_prev = 1'b1;
    logic       cs1_prev  = 1'b1;
    logic       dc1_prev  = 1'b1;
    logic [7:0] rx_shift  = 8'h00;
    int         rx_bits    = 0;
    int         rise_count = 0;
    int         cs_falls   = 0;
    int         cs_rises   = 0;
    int         bad_edges  = 0;
    logic [7:0] rx_bytes[$];

    always @(negedge CLK) begin
        scl1_prev <= scl1;
        cs1_prev  <= cs1;
        dc1_prev  <= dc1;
        if (cs1) begin
            rx_bits <= 0;
        end else if (!scl1_prev && scl1) begin
            rise_count <= rise_count + 1;
            rx_shift   <= {rx_shift[6:0], mosi1};
            if (rx_bits == 7) begin
                rx_bytes.push_back({rx_shift[6:0], mosi1});
                rx_bits <= 0;
            end else begin
                rx_bits <= rx_bits + 1;
            end
        end
        if (cs1_prev && !cs1) cs_falls <= cs_falls + 1;
        if (!cs1_prev && cs1) cs_rises <= cs_rises + 1;
        if (((cs1 !== cs1_prev) || (dc1 !== dc1_prev)) && (scl1 !== 1'b1))
            bad_edges <= bad_edges + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else begin
            checks_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send1(input logic [7:0] d, input logic dc, input logic last);
        int t;
        t = 0;
        while (!bus1.TX_READY && t < 1000) begin
            t++;
            @(negedge CLK);
        end
        if (!bus1.TX_READY) check("send1_ready_timeout", 32'd0, 32'd1);
        bus1.TX_VALID = 1'b1;
        bus1.TX_DATA  = d;
        bus1.TX_DC    = dc;
        bus1.TX_LAST  = last;
        last_accept   = cyc;
        @(negedge CLK);
        bus1.TX_VALID = 1'b0;
    endtask

    task automatic wait_cs1_high();
        int t;
        t = 0;
        while (!cs1 && t < 1000) begin
            t++;
            @(negedge CLK);
        end
        if (!cs1) check("cs1_high_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        int cs_low, rdy_low, gap, t, r0, b0, cf0, cr0, a0;
        int lvl_run, nlev, badlev, badb;
        logic lvl;
        logic [7:0] sh;

        bus1.TX_VALID = 1'b0; bus1.TX_DATA = 8'h00; bus1.TX_DC = 1'b0; bus1.TX_LAST = 1'b0;
        bus4.TX_VALID = 1'b0; bus4.TX_DATA = 8'h00; bus4.TX_DC = 1'b0; bus4.TX_LAST = 1'b0;
        RESET = 1'b1;
        repeat (3) @(negedge CLK);

        // Reset state
        check("rst_ready", bus1.TX_READY, 0);
        check("rst_scl",   scl1, 1);
        check("rst_cs",    cs1,  1);
        check("rst_dc",    dc1,  1);
        check("rst_mosi",  mosi1, 1);
        check("rst_busy",  bus1.BUSY, 0);
        RESET = 1'b0;
        #1;
        check("ready_after_rst", bus1.TX_READY, 1);
        @(negedge CLK);

        // Single framed command byte 0xB1
        r0 = rise_count; b0 = rx_bytes.size();
        send1(8'hB1, DC_CMD, 1'b1);
        check("b1_dc", dc1, 0);
        cs_low = 0; rdy_low = 0;
        while (cs1 == 1'b0 && cs_low < 200) begin
            cs_low++;
            if (!bus1.TX_READY) rdy_low++;
            @(negedge CLK);
        end
        check("b1_cs_low_cycles", cs_low, 18);
        check("b1_ready_low_cycles", rdy_low, 18);
        gap = 0;
        while (!bus1.TX_READY && gap < 200) begin
            gap++;
            @(negedge CLK);
        end
        check("b1_cs_gap", gap, 2);
        check("b1_rises", rise_count - r0, 8);
        check("b1_byte", rx_bytes[b0], 8'hB1);

        // Streamed CASET + parameter under one CS window
        r0 = rise_count; b0 = rx_bytes.size(); cr0 = cs_rises;
        send1(OP_CASET, DC_CMD, 1'b0);
        a0 = last_accept;
        check("stream_dc_cmd", dc1, 0);
        send1(8'h00, DC_DATA, 1'b1);
        check("stream_period", last_accept - a0, 19);
        check("stream_dc_data", dc1, 1);
        wait_cs1_high();
        check("stream_rises", rise_count - r0, 16);
        check("stream_cs_rises", cs_rises - cr0, 1);
        check("stream_byte0", rx_bytes[b0], 8'h2A);
        check("stream_byte1", rx_bytes[b0 + 1], 8'h00);

        // D=4 instance: every SCL level 4 cycles, 69 cycles CS low, 8-cycle gap
        bus4.TX_VALID = 1'b1; bus4.TX_DATA = 8'h96; bus4.TX_DC = DC_DATA; bus4.TX_LAST = 1'b1;
        @(negedge CLK);
        bus4.TX_VALID = 1'b0;
        check("d4_dc", dc4, 1);
        lvl = scl4; lvl_run = 0; nlev = 0; badlev = 0; cs_low = 0; sh = 8'h00;
        while (!cs4 && cs_low < 500) begin
            if (scl4 !== lvl) begin
                if (lvl_run != 4) badlev++;
                nlev++;
                if (scl4) sh = {sh[6:0], mosi4};
                lvl = scl4;
                lvl_run = 0;
            end
            lvl_run++;
            cs_low++;
            @(negedge CLK);
        end
        check("d4_scl_transitions", nlev, 16);
        check("d4_bad_levels", badlev, 0);
        check("d4_cs_low_cycles", cs_low, 69);
        check("d4_byte", sh, 8'h96);
        gap = 0;
        while (!bus4.TX_READY && gap < 200) begin
            gap++;
            @(negedge CLK);
        end
        check("d4_cs_gap", gap, 8);

        // TX_VALID held with changing data while busy
        b0 = rx_bytes.size(); cf0 = cs_falls;
        t = 0;
        while (!bus1.TX_READY && t < 200) begin t++; @(negedge CLK); end
        bus1.TX_VALID = 1'b1; bus1.TX_DATA = 8'hC3; bus1.TX_DC = DC_DATA; bus1.TX_LAST = 1'b1;
        @(negedge CLK);
        t = 0;
        while (!bus1.TX_READY && t < 200) begin
            bus1.TX_DATA = 8'(t * 37 + 5);
            t++;
            @(negedge CLK);
        end
        bus1.TX_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        check("hold_byte_count", rx_bytes.size() - b0, 1);
        check("hold_byte", rx_bytes[b0], 8'hC3);
        check("hold_cs_falls", cs_falls - cf0, 1);

        // Reset in the middle of 0xFF, then a clean 0x5A
        r0 = rise_count;
        send1(8'hFF, DC_CMD, 1'b1);
        t = 0;
        while ((rise_count - r0) < 4 && t < 200) begin t++; @(negedge CLK); end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("midrst_scl",   scl1, 1);
        check("midrst_cs",    cs1,  1);
        check("midrst_dc",    dc1,  1);
        check("midrst_mosi",  mosi1, 1);
        check("midrst_ready", bus1.TX_READY, 1);
        check("midrst_busy",  bus1.BUSY, 0);
        @(negedge CLK);
        r0 = rise_count; b0 = rx_bytes.size();
        send1(8'h5A, DC_DATA, 1'b1);
        wait_cs1_high();
        check("post_rst_rises", rise_count - r0, 8);
        check("post_rst_byte", rx_bytes[b0], 8'h5A);

        // Pixel burst in a single CS window
        b0 = rx_bytes.size(); cf0 = cs_falls; cr0 = cs_rises;
        for (int i = 0; i < BURST_N; i++) send1(8'hFF, DC_DATA, (i == BURST_N - 1));
        wait_cs1_high();
        check("burst_count", rx_bytes.size() - b0, BURST_N);
        check("burst_cs_falls", cs_falls - cf0, 1);
        check("burst_cs_rises", cs_rises - cr0, 1);
        badb = 0;
        for (int i = b0; i < rx_bytes.size(); i++) if (rx_bytes[i] !== 8'hFF) badb++;
        check("burst_bad_bytes", badb, 0);
        check("scl_high_at_cs_dc_change", bad_edges, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
